// File: rtl/go_pkg.sv
// Shared types and helpers for the move path between the input sources and
// the game FSM: the move encoding, board size and the arbiter state set.
package go_pkg;

   typedef logic [7:0] move_t;

   localparam move_t PASS_MOVE = 8'hFF;
   localparam int    BOARD_DIM = 9;

   typedef enum logic [1:0] {
      SELECT,
      ISSUE,
      WAIT_RESULT,
      GAME_DONE
   } arb_state_t;

   // True when both row and column of {row, col} fall on the board.
   function automatic logic move_is_legal_coord(input move_t m);
      return (m[7:4] < 4'(BOARD_DIM)) && (m[3:0] < 4'(BOARD_DIM));
   endfunction

endpackage

// File: rtl/move_slot.sv
// One-entry move buffer for a single source. Captures on valid && ready,
// drops malformed moves with a one-cycle reject pulse, empties on clear,
// and is flushed and closed while block is high. load_pass inserts a pass
// move into an empty slot as if it had been captured.
module move_slot
   import go_pkg::*;
(
   input  logic       clk_in,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [7:0] in_move,
   output logic       in_ready,
   input  logic       block,
   input  logic       clear,
   input  logic       load_pass,
   output logic       full,
   output logic [7:0] slot_move,
   output logic       reject
);

   logic  full_q, full_d;
   move_t data_q, data_d;
   logic  reject_q, reject_d;
   logic  capture;
   logic  well_formed;

   assign in_ready    = !full_q && !block;
   assign capture     = in_valid && in_ready;
   assign well_formed = move_is_legal_coord(in_move) || (in_move == PASS_MOVE);

   assign full      = full_q;
   assign slot_move = data_q;
   assign reject    = reject_q;

   // Next slot contents: flush/clear, capture or drop, or auto-pass load.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      full_d   = full_q;
      data_d   = data_q;
      reject_d = 1'b0;
      if (block || clear) begin
         full_d = 1'b0;
      end else if (capture) begin
         if (well_formed) begin
            full_d = 1'b1;
            data_d = in_move;
         end else begin
            reject_d = 1'b1;
         end
      end else if (load_pass && !full_q) begin
         full_d = 1'b1;
         data_d = PASS_MOVE;
      end
   end

   // Slot registers.
   always_ff @(posedge clk_in) begin
      // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
      if (reset) begin
         full_q   <= 1'b0;
         reject_q <= 1'b0;
      end else begin
         full_q   <= full_d;
         reject_q <= reject_d;
      end
      // NOTE: the payload is deliberately not reset; full_q qualifies it.
      data_q <= data_d;
   end

endmodule

// File: rtl/move_arbiter.sv
// Routes buffered moves from the local and remote sources into the game
// FSM's single move port, issuing only the source whose colour has the turn,
// and routes the FSM's accept (turn toggle) or reject back to that source.
// Optional feature: define AUTO_PASS_EN to auto-insert a pass after
// AUTO_PASS_CYCLES idle cycles on the local turn.
module move_arbiter
   import go_pkg::*;
#(
   parameter int RESULT_TIMEOUT   = 1024,
   parameter int AUTO_PASS_CYCLES = 50_000_000
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       local_valid,
   input  logic [7:0] local_move,
   output logic       local_ready,
   input  logic       remote_valid,
   input  logic [7:0] remote_move,
   output logic       remote_ready,
   input  logic       my_color,
   input  logic       turn,
   input  logic       invalid_move,
   input  logic       game_over,
   output logic       move_avail,
   output logic [7:0] move,
   output logic       local_reject,
   output logic       remote_reject,
   output logic       timeout_err,
   output logic       busy
);

   localparam int TIMER_W = $clog2(RESULT_TIMEOUT + 1);

   arb_state_t         state_q, state_d;
   move_t              move_q, move_d;
   logic               turn_at_issue_q, turn_at_issue_d;
   logic               src_local_q, src_local_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               move_avail_q, move_avail_d;
   logic               busy_q, busy_d;
   logic               local_rej_q, local_rej_d;
   logic               remote_rej_q, remote_rej_d;
   logic               timeout_q, timeout_d;

   logic  block;
   logic  local_turn;
   logic  local_clear, remote_clear;
   logic  local_full, remote_full;
   move_t local_slot_move, remote_slot_move;
   logic  local_slot_reject, remote_slot_reject;
   logic  auto_pass_load;

   assign block      = game_over || (state_q == GAME_DONE);
   assign local_turn = (turn == my_color);

   move_slot u_local_slot (
      .clk_in    (clk_in),
      .reset     (reset),
      .in_valid  (local_valid),
      .in_move   (local_move),
      .in_ready  (local_ready),
      .block     (block),
      .clear     (local_clear),
      .load_pass (auto_pass_load),
      .full      (local_full),
      .slot_move (local_slot_move),
      .reject    (local_slot_reject)
   );

   move_slot u_remote_slot (
      .clk_in    (clk_in),
      .reset     (reset),
      .in_valid  (remote_valid),
      .in_move   (remote_move),
      .in_ready  (remote_ready),
      .block     (block),
      .clear     (remote_clear),
      .load_pass (1'b0),
      .full      (remote_full),
      .slot_move (remote_slot_move),
      .reject    (remote_slot_reject)
   );

   // Arbiter next state: pick the turn-eligible slot, announce it, then
   // resolve accept / reject / timeout back onto the issuing source.
   always_comb begin
      state_d         = state_q;
      move_d          = move_q;
      turn_at_issue_d = turn_at_issue_q;
      src_local_d     = src_local_q;
      timer_d         = timer_q;
      timeout_d       = timeout_q;
      local_rej_d     = 1'b0;
      remote_rej_d    = 1'b0;
      local_clear     = 1'b0;
      remote_clear    = 1'b0;
      if (game_over) begin
         state_d = GAME_DONE;
      end else begin
         case (state_q)
            SELECT: begin
               if (local_turn && local_full) begin
                  move_d          = local_slot_move;
                  src_local_d     = 1'b1;
                  turn_at_issue_d = turn;
                  timer_d         = '0;
                  state_d         = ISSUE;
               end else if (!local_turn && remote_full) begin
                  move_d          = remote_slot_move;
                  src_local_d     = 1'b0;
                  turn_at_issue_d = turn;
                  timer_d         = '0;
                  state_d         = ISSUE;
               end
            end
            ISSUE: state_d = WAIT_RESULT;
            WAIT_RESULT: begin
               if (turn != turn_at_issue_q) begin
                  local_clear  = src_local_q;
                  remote_clear = !src_local_q;
                  state_d      = SELECT;
               end else if (invalid_move || (timer_q == TIMER_W'(RESULT_TIMEOUT))) begin
                  local_clear  = src_local_q;
                  remote_clear = !src_local_q;
                  local_rej_d  = src_local_q;
                  remote_rej_d = !src_local_q;
                  if (timer_q == TIMER_W'(RESULT_TIMEOUT)) timeout_d = 1'b1;
                  state_d      = SELECT;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            default: state_d = GAME_DONE;
         endcase
      end
      move_avail_d = (state_d == ISSUE);
      busy_d       = (state_d == ISSUE) || (state_d == WAIT_RESULT);
   end

   // Arbiter registers and registered outputs.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q         <= SELECT;
         move_q          <= '0;
         turn_at_issue_q <= 1'b0;
         src_local_q     <= 1'b0;
         timer_q         <= '0;
         move_avail_q    <= 1'b0;
         busy_q          <= 1'b0;
         local_rej_q     <= 1'b0;
         remote_rej_q    <= 1'b0;
         timeout_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         move_q          <= move_d;
         turn_at_issue_q <= turn_at_issue_d;
         src_local_q     <= src_local_d;
         timer_q         <= timer_d;
         move_avail_q    <= move_avail_d;
         busy_q          <= busy_d;
         local_rej_q     <= local_rej_d;
         remote_rej_q    <= remote_rej_d;
         timeout_q       <= timeout_d;
      end
   end

`ifdef AUTO_PASS_EN
   localparam int IDLE_W = $clog2(AUTO_PASS_CYCLES + 1);

   logic [IDLE_W-1:0] idle_q, idle_d;
   logic              turn_prev_q;

   // Idle counter on the local turn; loads a pass into the empty local slot.
   always_comb begin
      idle_d         = idle_q;
      auto_pass_load = 1'b0;
      if (game_over || (local_valid && local_ready) || (turn != turn_prev_q)) begin
         idle_d = '0;
      end else if ((state_q == SELECT) && local_turn && !local_full) begin
         if (idle_q == IDLE_W'(AUTO_PASS_CYCLES - 1)) begin
            auto_pass_load = 1'b1;
            idle_d         = '0;
         end else begin
            idle_d = idle_q + 1'b1;
         end
      end
   end

   // Idle counter and turn-change history.
   always_ff @(posedge clk_in) begin
      if (reset) idle_q <= '0;
      else       idle_q <= idle_d;
      turn_prev_q <= turn;
   end
`else
   assign auto_pass_load = 1'b0;
`endif

   assign move_avail    = move_avail_q;
   assign move          = move_q;
   assign busy          = busy_q;
   assign timeout_err   = timeout_q;
   assign local_reject  = local_rej_q || local_slot_reject;
   assign remote_reject = remote_rej_q || remote_slot_reject;

endmodule
